// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for serial_adder.
// master drives requests, slave (the adder) returns status and results.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             overflow;

    modport master (
        output start, a, b, cin, sub,
        input  busy, done, sum, carry, overflow
    );

    modport slave (
        input  start, a, b, cin, sub,
        output busy, done, sum, carry, overflow
    );
endinterface

// File: rtl/serial_adder.sv
// Digit-serial add/subtract: DIGIT bits per clock through a ripple slice with a
// registered carry; WIDTH/DIGIT steps per operation, start/busy/done handshake.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);
    localparam int N      = WIDTH / DIGIT;
    localparam int STEP_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0]  opa_q, opa_d, opb_q, opb_d, res_q, res_d, sum_q, sum_d;
    logic              cy_q, cy_d, carry_q, carry_d, ovf_q, ovf_d;
    logic [STEP_W-1:0] step_q, step_d;

    logic             accept, last;
    logic [DIGIT:0]   slice;
    logic             c_msb_in;
    logic [WIDTH-1:0] res_next;

    assign accept = bus.start && (state_q == IDLE || state_q == DONE);
    assign last   = (state_q == RUN) && (step_q == LAST_STEP);

    // Ripple slice; the carry into its top bit is recovered from the sum bit,
    // which on the final step is the carry into bit WIDTH-1.
    assign slice    = {1'b0, opa_q[DIGIT-1:0]} + {1'b0, opb_q[DIGIT-1:0]}
                    + {{DIGIT{1'b0}}, cy_q};
    assign c_msb_in = slice[DIGIT-1] ^ opa_q[DIGIT-1] ^ opb_q[DIGIT-1];

    generate
        if (DIGIT == WIDTH) begin : g_single
            assign res_next = slice[DIGIT-1:0];
        end else begin : g_shift
            assign res_next = {slice[DIGIT-1:0], res_q[WIDTH-1:DIGIT]};
        end
    endgenerate

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (last)      state_d = DONE;
            DONE:    state_d = bus.start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.busy     = (state_q == RUN);
        bus.done     = (state_q == DONE);
        bus.sum      = sum_q;
        bus.carry    = carry_q;
        bus.overflow = ovf_q;
    end

    always_comb begin
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        cy_d    = cy_q;
        step_d  = step_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        if (accept) begin
            opa_d  = bus.a;
            opb_d  = bus.sub ? ~bus.b : bus.b;
            cy_d   = bus.cin ^ bus.sub;
            step_d = '0;
        end else if (state_q == RUN) begin
            opa_d  = opa_q >> DIGIT;
            opb_d  = opb_q >> DIGIT;
            res_d  = res_next;
            cy_d   = slice[DIGIT];
            step_d = step_q + STEP_W'(1);
            if (last) begin
                sum_d   = res_next;
                carry_d = slice[DIGIT];
                ovf_d   = slice[DIGIT] ^ c_msb_in;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            cy_q    <= 1'b0;
            step_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            cy_q    <= cy_d;
            step_q  <= step_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: DIGIT=1 main instance plus DIGIT=4 and
// DIGIT=8 instances sharing the same stimulus.
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    serial_adder_if #(.WIDTH(8)) if1 ();
    serial_adder_if #(.WIDTH(8)) if4 ();
    serial_adder_if #(.WIDTH(8)) if8 ();

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (.clk(clk), .rst(rst), .bus(if1));
    serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (.clk(clk), .rst(rst), .bus(if4));
    serial_adder #(.WIDTH(8), .DIGIT(8)) u_d8 (.clk(clk), .rst(rst), .bus(if8));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic st, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic sub);
        if1.start = st; if1.a = a; if1.b = b; if1.cin = cin; if1.sub = sub;
        if4.start = st; if4.a = a; if4.b = b; if4.cin = cin; if4.sub = sub;
        if8.start = st; if8.a = a; if8.b = b; if8.cin = cin; if8.sub = sub;
    endtask

    // One operation on the DIGIT=1 instance, called #1 after a rising edge.
    task automatic op(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic cin, input logic sub,
                      input logic [7:0] es, input logic ec, input logic eo);
        int cnt;
        int nbusy;
        drive(1'b1, a, b, cin, sub);
        @(posedge clk); #1;
        drive(1'b0, ~a, ~b, ~cin, ~sub);
        cnt = 0;
        nbusy = 0;
        while (!if1.done && cnt < 40) begin
            if (if1.busy) nbusy++;
            @(posedge clk); #1;
            cnt++;
        end
        chk({tag, "_lat"},  cnt, 8);
        chk({tag, "_busy"}, nbusy, 8);
        chk({tag, "_sum"},  if1.sum, es);
        chk({tag, "_cy"},   if1.carry, ec);
        chk({tag, "_ovf"},  if1.overflow, eo);
        @(posedge clk); #1;
        chk({tag, "_done_drop"}, if1.done, 1'b0);
    endtask

    initial begin
        int nd;
        int dk[2];
        logic [7:0] ds[2];
        int l1, l4, l8;
        logic [7:0] s1, s4, s8;
        logic c4, c8, o4, o8;

        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", if1.busy, 1'b0);
        chk("rst_done", if1.done, 1'b0);
        chk("rst_sum",  if1.sum, 8'h00);
        rst = 1'b0;
        @(posedge clk); #1;

        op("add_0_1",   8'h00, 8'h01, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0);
        op("add_ff_1",  8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        op("add_7f_1",  8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        op("sub_5_7",   8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
        op("sub_80_1",  8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
        op("sub_10_0f", 8'h10, 8'h0F, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0);

        // start pulse with new operands during RUN must be ignored
        drive(1'b1, 8'h11, 8'h22, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        l1 = -1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (k == 3) drive(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1);
            if (k == 4) drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
            if (if1.done && l1 < 0) begin l1 = k; s1 = if1.sum; end
        end
        chk("ign_lat", l1, 8);
        chk("ign_sum", s1, 8'h33);

        // start held high through DONE: back-to-back operations
        drive(1'b1, 8'h01, 8'h02, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(1'b1, 8'h03, 8'h04, 1'b0, 1'b0);
        nd = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (k == 9) drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
            if (if1.done) begin
                if (nd < 2) begin dk[nd] = k; ds[nd] = if1.sum; end
                nd++;
            end
        end
        chk("b2b_count", nd, 2);
        chk("b2b_t0",    dk[0], 8);
        chk("b2b_t1",    dk[1], 17);
        chk("b2b_s0",    ds[0], 8'h03);
        chk("b2b_s1",    ds[1], 8'h07);

        // asynchronous reset mid-operation
        drive(1'b1, 8'h55, 8'h11, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_busy", if1.busy, 1'b0);
        chk("arst_done", if1.done, 1'b0);
        chk("arst_sum",  if1.sum, 8'h00);
        chk("arst_cy",   if1.carry, 1'b0);
        chk("arst_ovf",  if1.overflow, 1'b0);
        #9;
        rst = 1'b0;
        nd = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (if1.done) nd++;
        end
        chk("arst_no_done", nd, 0);
        op("post_rst", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);

        // same operation across DIGIT=1/4/8
        drive(1'b1, 8'h3C, 8'hC4, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        l1 = -1; l4 = -1; l8 = -1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (if1.done && l1 < 0) begin l1 = k; s1 = if1.sum; end
            if (if4.done && l4 < 0) begin l4 = k; s4 = if4.sum; c4 = if4.carry; o4 = if4.overflow; end
            if (if8.done && l8 < 0) begin l8 = k; s8 = if8.sum; c8 = if8.carry; o8 = if8.overflow; end
        end
        chk("d1_lat", l1, 8);
        chk("d1_sum", s1, 8'h00);
        chk("d4_lat", l4, 2);
        chk("d4_sum", s4, 8'h00);
        chk("d4_cy",  c4, 1'b1);
        chk("d4_ovf", o4, 1'b0);
        chk("d8_lat", l8, 1);
        chk("d8_sum", s8, 8'h00);
        chk("d8_cy",  c8, 1'b1);
        chk("d8_ovf", o8, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
